// File: rtl/add_share_pkg.sv
// -----------------------------------------------------------------------------
// add_share_pkg
// Shared types and helpers for the shared Kogge-Stone adder scheduler.
//   W        : operand width, fixed at 32 by the 5-level prefix tree
//   STAGES   : pipeline depth (stage 1, stage 2, output register)
//   pg_t     : generate/propagate vectors
//   stage_t  : one pipeline stage payload
//   rr_pick  : round-robin pick (first valid after ptr, wrapping at nreq)
// -----------------------------------------------------------------------------
package add_share_pkg;

    localparam int W        = 32;
    localparam int STAGES   = 3;
    localparam int IDW_MAX  = 2;   // enough for up to 4 requesters
    localparam int NREQ_MAX = 4;

    typedef struct packed {
        logic [W-1:0] g;
        logic [W-1:0] p;
    } pg_t;

    typedef struct packed {
        logic               valid;
        logic [IDW_MAX-1:0] id;
        logic               cin;
        logic               a_msb;
        logic               b_msb;
        logic [W-1:0]       hsum;  // bitwise a ^ b', survives the prefix levels for the final XOR
        pg_t                pg;    // group (G, P) after the prefix levels done so far
    } stage_t;

    typedef struct packed {
        logic               found;
        logic [IDW_MAX-1:0] idx;
    } rr_pick_t;

    // Scan ptr+1, ptr+2, ... modulo nreq and return the first valid index.
    function automatic rr_pick_t rr_pick(input logic [NREQ_MAX-1:0] valid,
                                         input logic [IDW_MAX-1:0]  ptr,
                                         input int                  nreq);
        rr_pick_t res;
        int       cand;
        res = '0;
        for (int i = 1; i <= NREQ_MAX; i++) begin
            cand = (int'(ptr) + i) % nreq;
            if ((i <= nreq) && !res.found && valid[cand[IDW_MAX-1:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[IDW_MAX-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/add_share_ksa_level.sv
// -----------------------------------------------------------------------------
// add_share_ksa_level
// One Kogge-Stone prefix level of span SPAN. Bits below SPAN already hold
// their complete prefix down to bit 0 and pass through unchanged.
//   i_pg : group (G, P) entering the level
//   o_pg : group (G, P) leaving the level
// -----------------------------------------------------------------------------
module add_share_ksa_level
    import add_share_pkg::*;
#(
    parameter int SPAN = 1
) (
    input  pg_t i_pg,
    output pg_t o_pg
);

    logic [W-1:0] w_g;
    logic [W-1:0] w_p;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            if (gi >= SPAN) begin : g_cell
                black_cell u_cell (
                    .i_g_hi (i_pg.g[gi]),
                    .i_p_hi (i_pg.p[gi]),
                    .i_g_lo (i_pg.g[gi-SPAN]),
                    .i_p_lo (i_pg.p[gi-SPAN]),
                    .o_g    (w_g[gi]),
                    .o_p    (w_p[gi])
                );
            end else begin : g_pass
                assign w_g[gi] = i_pg.g[gi];
                assign w_p[gi] = i_pg.p[gi];
            end
        end
    endgenerate

    assign o_pg = '{g: w_g, p: w_p};

endmodule

// File: rtl/add_share_rr_arb.sv
// -----------------------------------------------------------------------------
// add_share_rr_arb
// Round-robin arbiter holding the priority pointer. The requester right after
// the pointer has top priority; the pointer moves to the winner only when the
// handshake actually fires.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_en           : grants may be issued this cycle
//   i_req_valid    : per-requester valid
//   o_grant        : one-hot (or zero) ready towards the requesters
//   o_grant_id     : index of the winning requester
//   o_fire         : a handshake fires this cycle
// -----------------------------------------------------------------------------
module add_share_rr_arb
    import add_share_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic [NREQ-1:0]    i_req_valid,
    output logic [NREQ-1:0]    o_grant,
    output logic [IDW_MAX-1:0] o_grant_id,
    output logic               o_fire
);

    logic [IDW_MAX-1:0]  r_ptr;
    logic [NREQ_MAX-1:0] w_valid_ext;
    rr_pick_t            w_pick;

    always_comb begin
        w_valid_ext             = '0;
        w_valid_ext[NREQ-1:0]   = i_req_valid;
        w_pick                  = rr_pick(w_valid_ext, r_ptr, NREQ);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_grant
            assign o_grant[gi] = i_en && w_pick.found && (w_pick.idx == IDW_MAX'(gi));
        end
    endgenerate

    assign o_grant_id = w_pick.idx;
    assign o_fire     = i_en && w_pick.found;

    // Reset value NREQ-1 makes requester 0 the first in line.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= IDW_MAX'(NREQ - 1);
        end else if (o_fire) begin
            r_ptr <= w_pick.idx;
        end
    end

endmodule

// File: rtl/black_cell.sv
// -----------------------------------------------------------------------------
// black_cell
// Prefix operator: combines the upper group (Gik, Pik) with the lower group
// (Gkj, Pkj) into (Gij, Pij).
//   i_g_hi, i_p_hi : upper group generate / propagate
//   i_g_lo, i_p_lo : lower group generate / propagate
//   o_g, o_p       : combined group generate / propagate
// -----------------------------------------------------------------------------
module black_cell (
    input  logic i_g_hi,
    input  logic i_p_hi,
    input  logic i_g_lo,
    input  logic i_p_lo,
    output logic o_g,
    output logic o_p
);

    assign o_g = i_g_hi | (i_p_hi & i_g_lo);
    assign o_p = i_p_hi & i_p_lo;

endmodule

// File: rtl/add_share_sched.sv
// -----------------------------------------------------------------------------
// add_share_sched
// Shares one 3-stage pipelined 32-bit Kogge-Stone adder among NREQ requesters.
// Stage 1 registers bitwise g/p, stage 2 registers prefix spans 1/2/4, the
// output register holds the result after spans 8/16 and the carry-in fold.
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_flush         : kill everything in flight, no accept this cycle
//   i_req_valid     : per-requester valid
//   o_req_ready     : per-requester accept (one-hot or zero)
//   i_req_a/_b      : operands, requester k at [k*W +: W]
//   i_req_sub       : 1 = A-B, 0 = A+B
//   o_rsp_valid     : result valid, i_rsp_ready accepts it
//   o_rsp_id/_sum/_cout/_ovf : requester id, sum, carry out, signed overflow
//   o_inflight      : number of valid pipeline stages
// -----------------------------------------------------------------------------
module add_share_sched #(
    parameter int NREQ = 3,
    parameter int W    = 32,   // only 32 is supported by the prefix tree
    parameter int IDW  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic [NREQ-1:0]   i_req_valid,
    output logic [NREQ-1:0]   o_req_ready,
    input  logic [NREQ*W-1:0] i_req_a,
    input  logic [NREQ*W-1:0] i_req_b,
    input  logic [NREQ-1:0]   i_req_sub,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [IDW-1:0]    o_rsp_id,
    output logic [W-1:0]      o_rsp_sum,
    output logic              o_rsp_cout,
    output logic              o_rsp_ovf,
    output logic [1:0]        o_inflight
);

    import add_share_pkg::*;

    localparam int CNTW = $clog2(STAGES + 1);

    // ------------------------------------------------------------------ arbitration
    logic                w_adv;
    logic                w_en;
    logic                w_fire;
    logic [NREQ-1:0]     w_grant;
    logic [IDW_MAX-1:0]  w_grant_id;

    // Whole pipeline advances unless a valid result is being refused.
    assign w_adv = !(o_rsp_valid && !i_rsp_ready);
    // Reset is included so no ready is shown while the block is held in reset.
    assign w_en  = w_adv && !i_flush && i_rst_n;

    add_share_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_en        (w_en),
        .i_req_valid (i_req_valid),
        .o_grant     (w_grant),
        .o_grant_id  (w_grant_id),
        .o_fire      (w_fire)
    );

    assign o_req_ready = w_grant;

    // ------------------------------------------------------------------ stage 1 input
    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic [W-1:0] w_bp;
    logic         w_sub;
    stage_t       w_s1_next;

    // One-hot AND-OR select; the data is only meaningful when w_fire is set.
    always_comb begin
        w_a   = '0;
        w_b   = '0;
        w_sub = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_grant[k]) begin
                w_a   = i_req_a[k*W +: W];
                w_b   = i_req_b[k*W +: W];
                w_sub = i_req_sub[k];
            end
        end
    end

    assign w_bp = w_sub ? ~w_b : w_b;

    always_comb begin
        w_s1_next       = '0;
        w_s1_next.valid = w_fire;
        w_s1_next.id    = w_grant_id;
        w_s1_next.cin   = w_sub;
        w_s1_next.a_msb = w_a[W-1];
        w_s1_next.b_msb = w_bp[W-1];
        w_s1_next.hsum  = w_a ^ w_bp;
        w_s1_next.pg.p  = w_a ^ w_bp;
        w_s1_next.pg.g  = w_a & w_bp;
    end

    // ------------------------------------------------------------------ stage 2: spans 1, 2, 4
    stage_t r_s1;
    stage_t w_s2_next;
    pg_t    w_pg1;
    pg_t    w_pg2;
    pg_t    w_pg3;

    add_share_ksa_level #(.SPAN(1)) u_lvl1 (.i_pg(r_s1.pg), .o_pg(w_pg1));
    add_share_ksa_level #(.SPAN(2)) u_lvl2 (.i_pg(w_pg1),   .o_pg(w_pg2));
    add_share_ksa_level #(.SPAN(4)) u_lvl3 (.i_pg(w_pg2),   .o_pg(w_pg3));

    always_comb begin
        w_s2_next    = r_s1;
        w_s2_next.pg = w_pg3;
    end

    // ------------------------------------------------------------------ stage 3: spans 8, 16, cin, sum
    stage_t       r_s2;
    pg_t          w_pg4;
    pg_t          w_pg5;
    logic [W-1:0] w_carry;
    logic [W-1:0] w_sum;
    logic         w_ovf;

    add_share_ksa_level #(.SPAN(8))  u_lvl4 (.i_pg(r_s2.pg), .o_pg(w_pg4));
    add_share_ksa_level #(.SPAN(16)) u_lvl5 (.i_pg(w_pg4),   .o_pg(w_pg5));

    // After level 5 every bit holds its prefix down to bit 0; cin acts as g[-1].
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_carry
            assign w_carry[gi] = w_pg5.g[gi] | (w_pg5.p[gi] & r_s2.cin);
        end
    endgenerate

    assign w_sum = r_s2.hsum ^ {w_carry[W-2:0], r_s2.cin};
    assign w_ovf = (r_s2.a_msb == r_s2.b_msb) && (w_sum[W-1] != r_s2.a_msb);

    // ------------------------------------------------------------------ registers
    logic            r_out_valid;
    logic [IDW-1:0]  r_out_id;
    logic [W-1:0]    r_out_sum;
    logic            r_out_cout;
    logic            r_out_ovf;
    logic [CNTW-1:0] r_inflight;
    logic            w_v1_next;
    logic            w_v2_next;
    logic            w_v3_next;

    // Valid bits as they will be after this edge, so the count is never stale.
    assign w_v1_next = i_flush ? 1'b0 : (w_adv ? w_fire       : r_s1.valid);
    assign w_v2_next = i_flush ? 1'b0 : (w_adv ? r_s1.valid   : r_s2.valid);
    assign w_v3_next = i_flush ? 1'b0 : (w_adv ? r_s2.valid   : r_out_valid);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1        <= '0;
            r_s2        <= '0;
            r_out_valid <= 1'b0;
            r_out_id    <= '0;
            r_out_sum   <= '0;
            r_out_cout  <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_inflight  <= '0;
        end else begin
            r_inflight <= CNTW'({1'b0, w_v1_next}) + CNTW'({1'b0, w_v2_next})
                        + CNTW'({1'b0, w_v3_next});
            if (i_flush) begin
                r_s1.valid  <= 1'b0;
                r_s2.valid  <= 1'b0;
                r_out_valid <= 1'b0;
            end else if (w_adv) begin
                r_s1        <= w_s1_next;
                r_s2        <= w_s2_next;
                r_out_valid <= r_s2.valid;
                r_out_id    <= r_s2.id[IDW-1:0];
                r_out_sum   <= w_sum;
                r_out_cout  <= w_carry[W-1];
                r_out_ovf   <= w_ovf;
            end
        end
    end

    assign o_rsp_valid = r_out_valid;
    assign o_rsp_id    = r_out_id;
    assign o_rsp_sum   = r_out_sum;
    assign o_rsp_cout  = r_out_cout;
    assign o_rsp_ovf   = r_out_ovf;
    assign o_inflight  = r_inflight;

endmodule

// File: tb/tb_add_share_sched.sv
// -----------------------------------------------------------------------------
// tb_add_share_sched
// Drives add_share_sched with directed and randomized requests and compares
// every cycle against a transaction-level model: a 3-slot latency line, a
// round-robin pointer and results from plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_add_share_sched;

    localparam int NREQ = 3;
    localparam int W    = 32;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              flush;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_sub;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic              rsp_ovf;
    logic [1:0]        inflight;

    always #5 clk = ~clk;

    add_share_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_flush     (flush),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .i_req_sub   (req_sub),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_id    (rsp_id),
        .o_rsp_sum   (rsp_sum),
        .o_rsp_cout  (rsp_cout),
        .o_rsp_ovf   (rsp_ovf),
        .o_inflight  (inflight)
    );

    // Requester side
    bit          rq_v [NREQ];
    logic [31:0] rq_a [NREQ];
    logic [31:0] rq_b [NREQ];
    bit          rq_s [NREQ];

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            req_valid[k]       = rq_v[k];
            req_a[k*W +: W]    = rq_a[k];
            req_b[k*W +: W]    = rq_b[k];
            req_sub[k]         = rq_s[k];
        end
    end

    // Reference model state
    int          m_ptr;
    bit          m_v    [1:3];
    int          m_id   [1:3];
    logic [31:0] m_sum  [1:3];
    bit          m_cout [1:3];
    bit          m_ovf  [1:3];
    int          m_infl;
    int          m_fire_k;
    int          n_checks;
    int          n_errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Result from signed/unsigned integer arithmetic, independent of the prefix tree.
    function automatic void ref_op(input logic [31:0] a, input logic [31:0] b, input bit sub,
                                   output logic [31:0] s, output bit c, output bit v);
        longint sa, sb, ua, ub, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        if (sub) begin
            r = sa - sb;
            s = a - b;
            c = (ua >= ub);
        end else begin
            r = sa + sb;
            s = a + b;
            c = ((ua + ub) > 64'sd4294967295);
        end
        v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic model_reset();
        for (int s = 1; s <= 3; s++) m_v[s] = 1'b0;
        m_ptr    = NREQ - 1;
        m_infl   = 0;
        m_fire_k = -1;
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b, input bit s);
        rq_v[k] = 1'b1;
        rq_a[k] = a;
        rq_b[k] = b;
        rq_s[k] = s;
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < NREQ; k++) rq_v[k] = 1'b0;
    endtask

    // Called just after a falling edge with inputs applied: compare, step the
    // model over the coming rising edge, return at the next falling edge.
    task automatic cycle();
        bit            adv;
        int            g;
        int            c;
        bit [NREQ-1:0] exp_rdy;
        #1;
        check("rsp_valid", 64'(rsp_valid), 64'(m_v[3]));
        if (m_v[3]) begin
            check("rsp_id",   64'(rsp_id),   64'(m_id[3]));
            check("rsp_sum",  64'(rsp_sum),  64'(m_sum[3]));
            check("rsp_cout", 64'(rsp_cout), 64'(m_cout[3]));
            check("rsp_ovf",  64'(rsp_ovf),  64'(m_ovf[3]));
        end
        check("inflight", 64'(inflight), 64'(m_infl));

        adv = !(m_v[3] && !rsp_ready);
        g   = -1;
        for (int i = 1; i <= NREQ; i++) begin
            c = (m_ptr + i) % NREQ;
            if (g < 0 && rq_v[c]) g = c;
        end
        exp_rdy = '0;
        if (g >= 0 && adv && !flush) exp_rdy[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));

        m_fire_k = -1;
        if (flush) begin
            for (int s = 1; s <= 3; s++) m_v[s] = 1'b0;
        end else if (adv) begin
            for (int s = 3; s >= 2; s--) begin
                m_v[s]    = m_v[s-1];
                m_id[s]   = m_id[s-1];
                m_sum[s]  = m_sum[s-1];
                m_cout[s] = m_cout[s-1];
                m_ovf[s]  = m_ovf[s-1];
            end
            m_v[1] = (g >= 0);
            if (g >= 0) begin
                m_id[1] = g;
                ref_op(rq_a[g], rq_b[g], rq_s[g], m_sum[1], m_cout[1], m_ovf[1]);
                m_ptr    = g;
                m_fire_k = g;
            end
        end
        m_infl = int'(m_v[1]) + int'(m_v[2]) + int'(m_v[3]);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < NREQ; k++) set_req(k, 32'h0, 32'h0, 1'b0);
        model_reset();

        // ---------------- reset state, requests pending during reset
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_sum",   64'(rsp_sum),   64'd0);
        check("rst_rsp_id",    64'(rsp_id),    64'd0);
        check("rst_cout_ovf",  64'({rsp_cout, rsp_ovf}), 64'd0);
        check("rst_inflight",  64'(inflight),  64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_reqs();

        // ---------------- fairness: all requesters valid for 9 cycles
        for (int k = 0; k < NREQ; k++) set_req(k, 32'($urandom), 32'($urandom), 1'($urandom_range(0, 1)));
        for (int j = 0; j < 9; j++) begin
            #1 check("fair_grant", 64'(req_ready), 64'(NREQ'(1) << (j % NREQ)));
            cycle();
            check("fair_inflight", 64'(inflight), 64'((j >= 2) ? 3 : j + 1));
            if (m_fire_k >= 0) set_req(m_fire_k, 32'($urandom), 32'($urandom), 1'($urandom_range(0, 1)));
        end
        clear_reqs();
        repeat (3) cycle();

        // ---------------- directed add with signed overflow
        set_req(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        cycle();
        clear_reqs();
        repeat (2) cycle();
        check("tp_add_valid", 64'(rsp_valid), 64'd1);
        check("tp_add_id",    64'(rsp_id),    64'd0);
        check("tp_add_sum",   64'(rsp_sum),   64'h8000_0000);
        check("tp_add_cout",  64'(rsp_cout),  64'd0);
        check("tp_add_ovf",   64'(rsp_ovf),   64'd1);
        cycle();

        // ---------------- directed subtractions, borrow and no borrow
        set_req(1, 32'd5, 32'd7, 1'b1);
        cycle();
        set_req(1, 32'd7, 32'd5, 1'b1);
        cycle();
        clear_reqs();
        cycle();
        check("tp_sub1_sum",  64'(rsp_sum),  64'hFFFF_FFFE);
        check("tp_sub1_cout", 64'(rsp_cout), 64'd0);
        check("tp_sub1_ovf",  64'(rsp_ovf),  64'd0);
        check("tp_sub1_id",   64'(rsp_id),   64'd1);
        cycle();
        check("tp_sub2_sum",  64'(rsp_sum),  64'd2);
        check("tp_sub2_cout", 64'(rsp_cout), 64'd1);
        repeat (2) cycle();

        // ---------------- backpressure: fill, stall 4 cycles, drain
        for (int k = 0; k < NREQ; k++) set_req(k, rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
        for (int j = 0; j < 3; j++) begin
            cycle();
            if (m_fire_k >= 0) set_req(m_fire_k, rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
        end
        rsp_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            #1 check("bp_ready", 64'(req_ready), 64'd0);
            cycle();
        end
        rsp_ready = 1'b1;
        for (int j = 0; j < NREQ; j++) begin
            cycle();
            if (m_fire_k >= 0) rq_v[m_fire_k] = 1'b0;
        end
        repeat (3) cycle();
        check("bp_drained", 64'(inflight), 64'd0);

        // ---------------- flush with 3 in flight and req2 waiting
        set_req(0, rand_operand(), rand_operand(), 1'b0);
        for (int j = 0; j < 3; j++) begin
            cycle();
            set_req(0, rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
        end
        rq_v[0] = 1'b0;
        set_req(2, 32'h1234_5678, 32'h0000_0100, 1'b0);
        flush = 1'b1;
        #1 check("flush_pre_infl", 64'(inflight), 64'd3);
        check("flush_no_accept", 64'(req_ready), 64'd0);
        cycle();
        flush = 1'b0;
        check("flush_rsp_valid", 64'(rsp_valid), 64'd0);
        check("flush_inflight",  64'(inflight),  64'd0);
        #1 check("flush_req2_grant", 64'(req_ready), 64'b100);
        cycle();
        clear_reqs();
        repeat (3) cycle();

        // ---------------- randomized traffic with stalls and flushes
        for (int j = 0; j < 400; j++) begin
            for (int k = 0; k < NREQ; k++)
                if (!rq_v[k] && $urandom_range(0, 1) == 1)
                    set_req(k, rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
            rsp_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            cycle();
            if (m_fire_k >= 0) rq_v[m_fire_k] = 1'b0;
        end
        flush     = 1'b0;
        rsp_ready = 1'b1;
        for (int j = 0; j < NREQ; j++) begin
            cycle();
            if (m_fire_k >= 0) rq_v[m_fire_k] = 1'b0;
        end
        repeat (3) cycle();

        // ---------------- asynchronous reset mid-stall with 2 in flight
        set_req(0, rand_operand(), rand_operand(), 1'b0);
        cycle();
        set_req(0, rand_operand(), rand_operand(), 1'b1);
        cycle();
        rq_v[0] = 1'b0;
        cycle();
        rsp_ready = 1'b0;
        cycle();
        check("prerst_inflight", 64'(inflight), 64'd2);
        for (int k = 0; k < NREQ; k++) set_req(k, rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
        #2 rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("arst_rsp_data",  64'({rsp_id, rsp_cout, rsp_ovf}), 64'd0);
        check("arst_rsp_sum",   64'(rsp_sum),   64'd0);
        check("arst_inflight",  64'(inflight),  64'd0);
        check("arst_req_ready", 64'(req_ready), 64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #1 check("arst_req0_first", 64'(req_ready), 64'b001);
        for (int j = 0; j < NREQ; j++) begin
            cycle();
            if (m_fire_k >= 0) rq_v[m_fire_k] = 1'b0;
        end
        repeat (4) cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
